// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_keyboard_rx_pkg: shared PS/2 prefix codes, game key codes and frame FSM states
package ps2_keyboard_rx_pkg;
  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
  localparam logic [7:0] KEY_S       = 8'h1B;
  localparam logic [7:0] KEY_ESC     = 8'h76;
  localparam logic [7:0] KEY_P       = 8'h4D;
  localparam logic [7:0] KEY_R       = 8'h2D;
  localparam logic [7:0] KEY_UP      = 8'h75;
  localparam logic [7:0] KEY_RIGHT   = 8'h74;
  localparam logic [7:0] KEY_DOWN    = 8'h72;
  localparam logic [7:0] KEY_LEFT    = 8'h6B;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_t;
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins and deframes 11-bit frames with parity and timeout checks
module ps2_frame_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       parity_err,
  output logic       frame_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  ps2_state_t             state, state_n;
  logic [7:0]             sr;
  logic [2:0]             bitcnt;
  logic                   perr;
  logic [CW-1:0]          cnt;
  logic                   s_clk, s_data, fall, timeout;
  assign s_clk     = clk_sync[SYNC_STAGES-1];
  assign s_data    = data_sync[SYNC_STAGES-1];
  assign fall      = clk_prev & ~s_clk;
  assign timeout   = (state != ST_IDLE) & ~fall & (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign data_byte = sr;
  // pin synchronisers, idle-high after reset so reset never fakes a falling edge
  always_ff @(posedge clk)
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= s_clk;
    end
  // state register, shift register, parity latch and inactivity counter
  always_ff @(posedge clk)
    if (rst) begin
      state  <= ST_IDLE;
      sr     <= '0;
      bitcnt <= '0;
      perr   <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      cnt   <= (fall || state == ST_IDLE) ? '0 : cnt + 1'b1;
      if (fall && state == ST_IDLE) bitcnt <= '0;
      if (fall && state == ST_DATA) begin
        sr     <= {s_data, sr[7:1]};
        bitcnt <= bitcnt + 1'b1;
      end
      if (fall && state == ST_PARITY) perr <= ~(^sr ^ s_data);
    end
  // next state and single-cycle frame outcome strobes; a timeout overrides everything
  always_comb begin
    state_n    = state;
    byte_valid = 1'b0;
    parity_err = 1'b0;
    frame_err  = 1'b0;
    case (state)
      ST_IDLE:   state_n = (fall && !s_data) ? ST_DATA : ST_IDLE;
      ST_DATA:   state_n = (fall && bitcnt == 3'd7) ? ST_PARITY : ST_DATA;
      ST_PARITY: state_n = fall ? ST_STOP : ST_PARITY;
      ST_STOP: if (fall) begin
        state_n    = ST_IDLE;
        frame_err  = ~s_data;
        parity_err = s_data & perr;
        byte_valid = s_data & ~perr;
      end
      default:   state_n = ST_IDLE;
    endcase
    if (timeout) begin
      state_n   = ST_IDLE;
      frame_err = 1'b1;
    end
  end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: decodes PS/2 make/break/extended sequences into a held scan code and strobes
module ps2_keyboard_rx
  import ps2_keyboard_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scanCode,
  output logic       detected,
  output logic       extended,
  output logic       released,
  output logic       parity_err,
  output logic       frame_err
);
  logic [7:0] rx_byte;
  logic       rx_valid, rx_perr, rx_ferr;
  logic       ext_f, brk_f;
  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_frame (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (rx_byte),
    .byte_valid (rx_valid),
    .parity_err (rx_perr),
    .frame_err  (rx_ferr)
  );
  // prefix tracking and make/break decode; a break only clears scanCode for the same key
  always_ff @(posedge clk)
    if (rst) begin
      scanCode   <= 8'h00;
      extended   <= 1'b0;
      detected   <= 1'b0;
      released   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      ext_f      <= 1'b0;
      brk_f      <= 1'b0;
    end else begin
      detected   <= 1'b0;
      released   <= 1'b0;
      parity_err <= rx_perr;
      frame_err  <= rx_ferr;
      if (rx_valid) begin
        if (rx_byte == PS2_PFX_EXT) ext_f <= 1'b1;
        else if (rx_byte == PS2_PFX_BRK) brk_f <= 1'b1;
        else if (brk_f) begin
          released <= 1'b1;
          if (rx_byte == scanCode && ext_f == extended) begin
            scanCode <= 8'h00;
            extended <= 1'b0;
          end
          ext_f <= 1'b0;
          brk_f <= 1'b0;
        end else begin
          scanCode <= rx_byte;
          extended <= ext_f;
          detected <= 1'b1;
          ext_f    <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: PS/2 bus model driving directed frames, scoreboard-checked strobes
module tb_ps2_keyboard_rx;
  localparam int TO = 100;
  localparam int H  = 200;
  localparam int K_DET = 1, K_REL = 2, K_PERR = 3, K_FERR = 4;
  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
  } exp_t;
  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] scanCode;
  logic       detected, extended, released, parity_err, frame_err;
  int         vectors = 0, errors = 0, got;
  exp_t       q[$];
  exp_t       e;
  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scanCode   (scanCode),
    .detected   (detected),
    .extended   (extended),
    .released   (released),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );
  always #10 clk = ~clk;
  function automatic logic [10:0] frame(input logic [7:0] b, input logic flip_par, input logic stop);
    return {stop, ~^b ^ flip_par, b, 1'b0};
  endfunction
  task automatic send(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      #(H/2) ps2_data = f[i];
      #(H/2) ps2_clk = 1'b0;
      #(H) ps2_clk = 1'b1;
    end
    #(H/2) ps2_data = 1'b1;
    #(5*H);
  endtask
  task automatic key(input logic [7:0] b);
    send(frame(b, 1'b0, 1'b1), 11);
  endtask
  task automatic expect_ev(input int kind, input logic [7:0] code, input logic ext);
    q.push_back('{kind, code, ext});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  // monitor: every strobe pops one expectation and checks kind and the held outputs
  always @(negedge clk)
    if (detected | released | parity_err | frame_err) begin
      vectors++;
      got = detected ? K_DET : released ? K_REL : parity_err ? K_PERR : K_FERR;
      if ($countones({detected, released, parity_err, frame_err}) != 1) begin
        errors++;
        $display("FAIL exclusive: strobes %b, expected one-hot", {detected, released, parity_err, frame_err});
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: strobe kind %0d, expected none", got);
      end else begin
        e = q.pop_front();
        if (got != e.kind || scanCode !== e.code || extended !== e.ext) begin
          errors++;
          $display("FAIL event: kind %0d code %h ext %b, expected kind %0d code %h ext %b",
                   got, scanCode, extended, e.kind, e.code, e.ext);
        end
      end
    end
  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_scan", scanCode, 8'h00);
    chk("rst_ext", extended, 1'b0);
    chk("rst_pulses", {detected, released, parity_err, frame_err}, 4'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    expect_ev(K_DET, 8'h1B, 1'b0);
    key(8'h1B);
    expect_ev(K_DET, 8'h75, 1'b1);
    key(8'hE0); key(8'h75);
    expect_ev(K_REL, 8'h00, 1'b0);
    key(8'hE0); key(8'hF0); key(8'h75);
    expect_ev(K_PERR, 8'h00, 1'b0);
    send(frame(8'h4D, 1'b1, 1'b1), 11);
    expect_ev(K_FERR, 8'h00, 1'b0);
    send(frame(8'h2D, 1'b0, 1'b1), 5);
    repeat (3*TO) @(posedge clk);
    expect_ev(K_FERR, 8'h00, 1'b0);
    send(frame(8'h2D, 1'b0, 1'b0), 11);
    expect_ev(K_DET, 8'h2D, 1'b0);
    key(8'h2D);
    expect_ev(K_DET, 8'h74, 1'b0);
    key(8'h74);
    expect_ev(K_REL, 8'h74, 1'b0);
    key(8'hF0); key(8'h6B);
    for (int i = 0; i < 3; i++) begin
      expect_ev(K_DET, 8'h74, 1'b0);
      key(8'h74);
    end
    send(frame(8'h76, 1'b0, 1'b1), 4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_scan", scanCode, 8'h00);
    chk("midrst_ext", extended, 1'b0);
    chk("midrst_pulses", {detected, released, parity_err, frame_err}, 4'b0);
    expect_ev(K_DET, 8'h76, 1'b0);
    key(8'h76);
    repeat (50) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_scan", scanCode, 8'h76);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
